// File: rtl/cpu_defs.sv
// Shared CPU definitions.
// Holds the data-memory responder state encoding, the word size in bytes,
// and the default depth / wait-state constants used by dmem_responder.
package cpu_defs;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_BYTES          = 4;
    localparam int DMEM_DEPTH_DEFAULT  = 256;
    localparam int DMEM_WAIT_DEFAULT   = 2;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - async active-low reset (read register only; storage is not reset)
//   we    - write enable, writes wdata to mem[addr] at the clock edge
//   re    - read enable, loads rdata from mem[addr] at the clock edge
//   addr  - word index
//   wdata - write data
//   rdata - registered read data, holds until the next enabled read
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MIPS core.
// Serves word loads/stores with WAIT_CYCLES wait states and a registered
// one-cycle ready pulse; malformed accesses complete with err and never
// touch storage.
// Ports:
//   clk, clr_n          - clock and async active-low reset
//   mem_read, mem_write - request, held until ready
//   addr, wdata         - byte address (word aligned) and store data
//   rdata               - registered load data, changes only on valid reads
//   ready, err          - completion pulse and its error qualifier
//   busy                - access in flight
//
// state  | meaning
// IDLE   | waiting for a request; accepts on any edge with a request
// WAIT   | wait states, cnt counting down to 0
// RESP   | ready high for one cycle, storage access done on entry
module dmem_responder
    import cpu_defs::*;
#(
    parameter int DEPTH       = DMEM_DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = DMEM_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OFS_W = $clog2(WORD_BYTES);

    dmem_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          rd_q, wr_q, bad_q;
    logic          capture, go_resp;

    logic          req, bad_in;
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_rd, acc_wr, acc_bad;

    assign req    = mem_read | mem_write;
    assign bad_in = (addr[OFS_W-1:0] != '0)
                  | (addr[31:OFS_W+AW] != '0)
                  | (mem_read & mem_write);

    // With zero wait states the storage access happens on the accepting
    // edge itself, so the operands come straight from the request lines.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr  = addr[OFS_W+AW-1:OFS_W];
            acc_wdata = wdata;
            acc_rd    = mem_read;
            acc_wr    = mem_write;
            acc_bad   = bad_in;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_rd    = rd_q;
            acc_wr    = wr_q;
            acc_bad   = bad_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        go_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= addr[OFS_W+AW-1:OFS_W];
                wdata_q <= wdata;
                rd_q    <= mem_read;
                wr_q    <= mem_write;
                bad_q   <= bad_in;
            end
            ready <= go_resp;
            err   <= go_resp & acc_bad;
            busy  <= (state_d != S_IDLE);
        end
    end

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .rst_n (clr_n),
        .we    (go_resp & acc_wr & ~acc_bad),
        .re    (go_resp & acc_rd & ~acc_bad),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        clr0_n, rd0, wr0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, busy0, err0;
    logic        clr1_n, rd1, wr1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ready1, busy1, err1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .clr_n(clr0_n), .mem_read(rd0), .mem_write(wr0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0),
        .ready(ready0), .busy(busy0), .err(err0)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .clr_n(clr1_n), .mem_read(rd1), .mem_write(wr1),
        .addr(addr1), .wdata(wdata1), .rdata(rdata1),
        .ready(ready1), .busy(busy1), .err(err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Called #1 after a rising edge; returns #1 after the edge back into IDLE.
    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int stamp,
                          output logic [31:0] rdat, output logic e);
        logic got;
        if (sel == 0) begin rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d; end
        else          begin rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d; end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            got = (sel == 0) ? ready0 : ready1;
        end
        stamp = cyc;
        total++;
        if (got !== 1'b1) begin
            bad++;
            $display("FAIL ready_timeout sel=%0d addr=%h got=%b want=1", sel, a, got);
        end
        rdat = (sel == 0) ? rdata0 : rdata1;
        e    = (sel == 0) ? err0 : err1;
        if (sel == 0) begin rd0 = 1'b0; wr0 = 1'b0; end
        else          begin rd1 = 1'b0; wr1 = 1'b0; end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr0_n = 1'b0; clr1_n = 1'b0;
        rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
        #12;
        total++;
        if ({ready0, busy0, err0} !== 3'b000 || rdata0 !== 32'h0) begin
            bad++;
            $display("FAIL reset0 got r/b/e=%b%b%b rdata=%h want 000 0", ready0, busy0, err0, rdata0);
        end
        total++;
        if ({ready1, busy1, err1} !== 3'b000 || rdata1 !== 32'h0) begin
            bad++;
            $display("FAIL reset1 got r/b/e=%b%b%b rdata=%h want 000 0", ready1, busy1, err1, rdata1);
        end
        clr0_n = 1'b1; clr1_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, st;
        logic [31:0] rv;
        logic e;
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, st, rv, e);
        total++;
        if (lat !== 3 || e !== 1'b0) begin
            bad++;
            $display("FAIL basic_write lat=%0d err=%b want lat=3 err=0", lat, e);
        end
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, st, rv, e);
        total++;
        if (lat !== 3 || e !== 1'b0 || rv !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL basic_read lat=%0d err=%b rdata=%h want 3 0 deadbeef", lat, e, rv);
        end
    endtask

    task automatic test_back_to_back();
        int lat, st, prev;
        logic [31:0] rv;
        logic e;
        logic        rds [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] as  [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
        logic [31:0] ds  [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0, 32'h0};
        logic [31:0] ex  [4] = '{32'h0, 32'h0, 32'hA0A0A0A0, 32'hB1B1B1B1};
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            access(1, rds[i], !rds[i], as[i], ds[i], lat, st, rv, e);
            total++;
            if (lat !== 1 || e !== 1'b0) begin
                bad++;
                $display("FAIL b2b_lat[%0d] lat=%0d err=%b want 1 0", i, lat, e);
            end
            if (i > 0) begin
                total++;
                if (st - prev !== 2) begin
                    bad++;
                    $display("FAIL b2b_period[%0d] got=%0d want=2", i, st - prev);
                end
            end
            if (rds[i]) begin
                total++;
                if (rv !== ex[i]) begin
                    bad++;
                    $display("FAIL b2b_data[%0d] got=%h want=%h", i, rv, ex[i]);
                end
            end
            prev = st;
        end
    endtask

    task automatic test_errors();
        int lat, st;
        logic [31:0] rv;
        logic e;
        access(1, 1'b1, 1'b0, 32'h2, 32'h0, lat, st, rv, e);
        total++;
        if (e !== 1'b1 || rv !== 32'hB1B1B1B1) begin
            bad++;
            $display("FAIL err_misaligned err=%b rdata=%h want 1 b1b1b1b1", e, rv);
        end
        access(1, 1'b1, 1'b0, 32'h400, 32'h0, lat, st, rv, e);
        total++;
        if (e !== 1'b1 || rv !== 32'hB1B1B1B1) begin
            bad++;
            $display("FAIL err_range_read err=%b rdata=%h want 1 b1b1b1b1", e, rv);
        end
        access(1, 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, lat, st, rv, e);
        total++;
        if (e !== 1'b1 || rv !== 32'hB1B1B1B1) begin
            bad++;
            $display("FAIL err_range_write err=%b rdata=%h want 1 b1b1b1b1", e, rv);
        end
        access(1, 1'b0, 1'b1, 32'h6, 32'hEEEEEEEE, lat, st, rv, e);
        total++;
        if (e !== 1'b1) begin
            bad++;
            $display("FAIL err_misaligned_write err=%b want 1", e);
        end
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, lat, st, rv, e);
        total++;
        if (e !== 1'b0 || rv !== 32'hA0A0A0A0) begin
            bad++;
            $display("FAIL err_storage0 err=%b rdata=%h want 0 a0a0a0a0", e, rv);
        end
        access(1, 1'b1, 1'b0, 32'h4, 32'h0, lat, st, rv, e);
        total++;
        if (e !== 1'b0 || rv !== 32'hB1B1B1B1) begin
            bad++;
            $display("FAIL err_storage4 err=%b rdata=%h want 0 b1b1b1b1", e, rv);
        end
    endtask

    task automatic test_both_high();
        int lat, st;
        logic [31:0] rv;
        logic e;
        access(1, 1'b0, 1'b1, 32'h8, 32'h11111111, lat, st, rv, e);
        access(1, 1'b1, 1'b1, 32'h8, 32'h22222222, lat, st, rv, e);
        total++;
        if (e !== 1'b1 || rv !== 32'hB1B1B1B1) begin
            bad++;
            $display("FAIL both_high err=%b rdata=%h want 1 b1b1b1b1", e, rv);
        end
        access(1, 1'b1, 1'b0, 32'h8, 32'h0, lat, st, rv, e);
        total++;
        if (e !== 1'b0 || rv !== 32'h11111111) begin
            bad++;
            $display("FAIL both_high_readback err=%b rdata=%h want 0 11111111", e, rv);
        end
    endtask

    task automatic test_capture();
        int lat, st, n;
        logic [31:0] rv;
        logic e, got;
        access(0, 1'b0, 1'b1, 32'h24, 32'h00000077, lat, st, rv, e);
        wr0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hA5A5A5A5;
        @(posedge clk); #1;
        addr0 = 32'h24; wdata0 = 32'h12345678;
        got = 1'b0;
        n = 1;
        total++;
        if (busy0 !== 1'b1) begin
            bad++;
            $display("FAIL capture_busy_A got=%b want=1", busy0);
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            n++;
            got = ready0;
            total++;
            if (busy0 !== 1'b1) begin
                bad++;
                $display("FAIL capture_busy[%0d] got=%b want=1", i, busy0);
            end
        end
        total++;
        if (got !== 1'b1 || n !== 3) begin
            bad++;
            $display("FAIL capture_ready got=%b lat=%0d want 1 3", got, n);
        end
        wr0 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy0 !== 1'b0 || ready0 !== 1'b0) begin
            bad++;
            $display("FAIL capture_idle busy=%b ready=%b want 0 0", busy0, ready0);
        end
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, st, rv, e);
        total++;
        if (rv !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL capture_addr20 got=%h want=a5a5a5a5", rv);
        end
        access(0, 1'b1, 1'b0, 32'h24, 32'h0, lat, st, rv, e);
        total++;
        if (rv !== 32'h00000077) begin
            bad++;
            $display("FAIL capture_addr24 got=%h want=00000077", rv);
        end
    endtask

    task automatic test_reset_mid();
        int lat, st;
        logic [31:0] rv;
        logic e;
        access(0, 1'b0, 1'b1, 32'hC, 32'h00000033, lat, st, rv, e);
        wr0 = 1'b1; addr0 = 32'hC; wdata0 = 32'h00000055;
        @(posedge clk); #1;
        total++;
        if (busy0 !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_busy_before got=%b want=1", busy0);
        end
        #2 clr0_n = 1'b0;
        #1;
        total++;
        if ({ready0, busy0, err0} !== 3'b000 || rdata0 !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_async r/b/e=%b%b%b rdata=%h want 000 0", ready0, busy0, err0, rdata0);
        end
        wr0 = 1'b0;
        #2 clr0_n = 1'b1;
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'hC, 32'h0, lat, st, rv, e);
        total++;
        if (rv !== 32'h00000033 || e !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_storage got=%h err=%b want 00000033 0", rv, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_errors();
        test_both_high();
        test_capture();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
